// File: rtl/calc_input_pkg.sv
// rtl/calc_input_pkg.sv - state encodings and counter width helper for the key event classifier
package calc_input_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_LONG  = 2'd2
  } state_t;

  function automatic int cnt_width(input int unsigned a, input int unsigned b, input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_channel.sv
// rtl/key_channel.sv - one key: synchroniser, debouncer, press FSM
// Optional auto-repeat under KEY_EVENT_REPEAT_EN.
module key_channel
  import calc_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE      = 250000,
  parameter int unsigned LONG_CRIT     = 12500000,
  parameter int unsigned REPEAT_PERIOD = 2500000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic btn,
  output logic pressed,
  output logic short,
  output logic long,
  output logic rpt
);

  localparam int CNT_W = cnt_width(DEBOUNCE, LONG_CRIT, REPEAT_PERIOD);

  logic [1:0]       sy;
  logic [CNT_W-1:0] dc;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             short_nxt, long_nxt;
  state_t           state, state_nxt;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sy      <= '0;
      dc      <= '0;
      pressed <= 1'b0;
    end else begin
      sy <= {sy[0], btn};
      if (sy[1] != pressed) begin
        if (dc == CNT_W'(DEBOUNCE - 1)) begin
          pressed <= sy[1];
          dc      <= '0;
        end else begin
          dc <= dc + CNT_W'(1);
        end
      end else begin
        dc <= '0;
      end
    end
  end

`ifdef KEY_EVENT_REPEAT_EN
  logic [CNT_W-1:0] rc, rc_nxt;
  logic             rpt_nxt;
`else
  assign rpt = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      short <= 1'b0;
      long  <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
      rc    <= '0;
      rpt   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      short <= short_nxt;
      long  <= long_nxt;
`ifdef KEY_EVENT_REPEAT_EN
      rc    <= rc_nxt;
      rpt   <= rpt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pressed) state_nxt = S_PRESS;
      S_PRESS: begin
        if (!pressed)       state_nxt = S_IDLE;
        else if (cnt == '0) state_nxt = S_LONG;
      end
      S_LONG:  if (!pressed) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Release is checked before the terminal count so a release on the last cycle still reports short.
  always_comb begin
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
    cnt_nxt   = cnt;
`ifdef KEY_EVENT_REPEAT_EN
    rc_nxt    = rc;
    rpt_nxt   = 1'b0;
`endif
    case (state)
      S_IDLE:  if (pressed) cnt_nxt = CNT_W'(LONG_CRIT - 1);
      S_PRESS: begin
        if (!pressed) begin
          short_nxt = 1'b1;
        end else if (cnt == '0) begin
          long_nxt = 1'b1;
`ifdef KEY_EVENT_REPEAT_EN
          rc_nxt   = CNT_W'(REPEAT_PERIOD - 1);
`endif
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_LONG: begin
`ifdef KEY_EVENT_REPEAT_EN
        if (pressed) begin
          if (rc == '0) begin
            rpt_nxt = 1'b1;
            rc_nxt  = CNT_W'(REPEAT_PERIOD - 1);
          end else begin
            rc_nxt = rc - CNT_W'(1);
          end
        end
`endif
      end
      default: cnt_nxt = '0;
    endcase
  end

endmodule

// File: rtl/key_event_classifier.sv
// rtl/key_event_classifier.sv - N_CH independent short/long key press classifiers
// Auto-repeat enabled by defining KEY_EVENT_REPEAT_EN.
module key_event_classifier #(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned DEBOUNCE      = 250000,
  parameter int unsigned LONG_CRIT     = 12500000,
  parameter int unsigned REPEAT_PERIOD = 2500000
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] pressed,
  output logic [N_CH-1:0] short,
  output logic [N_CH-1:0] long,
  output logic [N_CH-1:0] rpt
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    key_channel #(
      .DEBOUNCE     (DEBOUNCE),
      .LONG_CRIT    (LONG_CRIT),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .Clock  (Clock),
      .Reset  (Reset),
      .btn    (btn[i]),
      .pressed(pressed[i]),
      .short  (short[i]),
      .long   (long[i]),
      .rpt    (rpt[i])
    );
  end

endmodule

// File: tb/tb_key_event_classifier.sv
// tb/tb_key_event_classifier.sv - directed bench for key_event_classifier
// Expected repeat behaviour follows KEY_EVENT_REPEAT_EN.
module tb_key_event_classifier;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [1:0] btn   = 2'b00;
  logic [1:0] pressed, short, long, rpt;

  int n_vec = 0;
  int n_err = 0;
  int edge_n;
  int n_short[2], n_long[2], n_rpt[2];
  int f_short[2], f_long[2], f_rpt[2], f_press[2];
  int p_seen[2];

  key_event_classifier #(
    .N_CH(2), .DEBOUNCE(4), .LONG_CRIT(20), .REPEAT_PERIOD(8)
  ) dut (
    .Clock(Clock), .Reset(Reset), .btn(btn),
    .pressed(pressed), .short(short), .long(long), .rpt(rpt)
  );

  always #5 Clock = ~Clock;

  task automatic clear_rec();
    edge_n = 0;
    for (int c = 0; c < 2; c++) begin
      n_short[c] = 0; n_long[c] = 0; n_rpt[c] = 0;
      f_short[c] = -1; f_long[c] = -1; f_rpt[c] = -1; f_press[c] = -1;
      p_seen[c] = 0;
    end
  endtask

  // Edge numbers count posedges since the last clear_rec.
  task automatic tick();
    @(posedge Clock);
    #1;
    edge_n++;
    for (int c = 0; c < 2; c++) begin
      if (short[c]) begin n_short[c]++; if (f_short[c] < 0) f_short[c] = edge_n; end
      if (long[c])  begin n_long[c]++;  if (f_long[c] < 0)  f_long[c]  = edge_n; end
      if (rpt[c])   begin n_rpt[c]++;   if (f_rpt[c] < 0)   f_rpt[c]   = edge_n; end
      if (pressed[c]) begin p_seen[c] = 1; if (f_press[c] < 0) f_press[c] = edge_n; end
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int exp_rpt_n, exp_rpt_f;
`ifdef KEY_EVENT_REPEAT_EN
    exp_rpt_n = 4; exp_rpt_f = 35;
`else
    exp_rpt_n = 0; exp_rpt_f = -1;
`endif

    // 1: reset with keys held
    clear_rec();
    btn = 2'b11;
    ticks(4);
    check("rst_pressed", int'(pressed), 0);
    check("rst_short",   int'(short),   0);
    check("rst_long",    int'(long),    0);
    check("rst_rpt",     int'(rpt),     0);
    btn = 2'b00;
    Reset = 1'b1;
    clear_rec();
    ticks(10);
    check("rst_exit_events", n_short[0] + n_short[1] + n_long[0] + n_long[1] + n_rpt[0] + n_rpt[1], 0);
    check("rst_exit_pressed", p_seen[0] + p_seen[1], 0);

    // 2: short press on ch0
    clear_rec();
    btn = 2'b01;
    ticks(12);
    btn = 2'b00;
    ticks(20);
    check("t2_press_edge", f_press[0], 6);
    check("t2_short_cnt",  n_short[0], 1);
    check("t2_short_edge", f_short[0], 19);
    check("t2_long_cnt",   n_long[0],  0);
    check("t2_ch1_quiet",  n_short[1] + n_long[1] + p_seen[1], 0);

    // 3: long press on ch0
    clear_rec();
    btn = 2'b01;
    ticks(60);
    btn = 2'b00;
    ticks(20);
    check("t3_long_cnt",   n_long[0],  1);
    check("t3_long_edge",  f_long[0],  27);
    check("t3_short_cnt",  n_short[0], 0);
    check("t3_rpt_cnt",    n_rpt[0],   exp_rpt_n);
    check("t3_rpt_edge",   f_rpt[0],   exp_rpt_f);
    check("t3_released",   int'(pressed[0]), 0);

    // 4: glitch train on ch1
    clear_rec();
    for (int g = 0; g < 5; g++) begin
      btn = 2'b10; ticks(3);
      btn = 2'b00; ticks(3);
    end
    ticks(10);
    check("t4_pressed", p_seen[1], 0);
    check("t4_events",  n_short[1] + n_long[1] + n_rpt[1], 0);

    // 5: both channels together
    clear_rec();
    btn = 2'b11;
    ticks(60);
    btn = 2'b00;
    ticks(20);
    check("t5_long0_edge", f_long[0], 27);
    check("t5_long1_edge", f_long[1], 27);
    check("t5_long0_cnt",  n_long[0], 1);
    check("t5_long1_cnt",  n_long[1], 1);
    check("t5_shorts",     n_short[0] + n_short[1], 0);

    // 6: reset in the middle of a press
    clear_rec();
    btn = 2'b01;
    ticks(15);
    Reset = 1'b0;
    ticks(2);
    check("t6_rst_pressed", int'(pressed), 0);
    check("t6_pre_events",  n_short[0] + n_long[0], 0);
    clear_rec();
    Reset = 1'b1;
    ticks(40);
    check("t6_press_edge", f_press[0], 6);
    check("t6_long_edge",  f_long[0], 27);
    check("t6_long_delay", f_long[0] - f_press[0], 21);
    check("t6_short_cnt",  n_short[0], 0);
    btn = 2'b00;
    ticks(20);
    check("t6_no_short_after", n_short[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
